// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode field bounds,
// the NOP word and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2
    } if_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Two-entry prefetch FIFO holding {pc, instr} pairs. Head outputs read NOP/0
// when empty; flush discards everything in one cycle.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  logic [63:0] push_data_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic [63:0] head_o,
    output logic        valid_o,
    output logic [1:0]  count_o,
    output logic [1:0]  count_next_o
);

    logic [63:0] mem_q [2];
    logic        rd_ptr_q;
    logic        wr_ptr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        push_ok;
    logic        pop_ok;

    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i && (count_q != 2'd0);

    always_comb begin
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (push_ok) begin
                    mem_q[wr_ptr_q] <= push_data_i;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop_ok) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    assign valid_o      = (count_q != 2'd0);
    assign head_o       = valid_o ? mem_q[rd_ptr_q] : {32'h0, NOP_INSTR};
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential PC generation, req/ack instruction memory access,
// prefetch buffering and branch redirect with stale-response discard.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  fsm_state
);

    // Handshakes: imem_req is held with a stable imem_addr until imem_ack;
    // the decode side pops the head on any cycle with instr_valid & instr_ready.
    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;

    logic        push;
    logic        pop;
    logic        room;
    logic [31:0] pc_inc;
    logic [31:0] redir_pc;
    logic [63:0] head;
    logic [1:0]  count;
    logic [1:0]  count_next;

    assign pop      = instr_valid && instr_ready && !redirect_valid;
    assign push     = (state_q == IF_REQ) && imem_ack && !redirect_valid;
    assign room     = count_next < 2'(FIFO_DEPTH);
    assign pc_inc   = pc_q + 32'd4;
    assign redir_pc = align_pc(redirect_pc);

    fetch_fifo u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_data_i  ({addr_q, imem_rdata}),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .head_o       (head),
        .valid_o      (instr_valid),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // Issue looks at the post-edge occupancy, so an ack can chain straight
    // into the next request and sustain one word per cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IF_IDLE;
            pc_q    <= align_pc(RESET_PC);
            addr_q  <= align_pc(RESET_PC);
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc;
                    end else if (room) begin
                        state_q <= IF_REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                IF_REQ: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            state_q <= IF_IDLE;
                            req_q   <= 1'b0;
                            pc_q    <= redir_pc;
                        end else begin
                            pc_q <= pc_inc;
                            if (room) begin
                                addr_q <= pc_inc;
                            end else begin
                                state_q <= IF_IDLE;
                                req_q   <= 1'b0;
                            end
                        end
                    end else if (redirect_valid) begin
                        state_q <= IF_DROP;
                        pc_q    <= redir_pc;
                    end
                end
                IF_DROP: begin
                    if (redirect_valid) begin
                        pc_q <= redir_pc;
                    end
                    if (imem_ack) begin
                        state_q <= IF_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IF_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign instr     = head[31:0];
    assign instr_pc  = head[63:32];
    assign op        = instr[OP_MSB:OP_LSB];
    assign fsm_state = state_q;

endmodule
